// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-pass shift sequencer and its shifter datapath.
// Opcodes, the per-pass step limit and the controller state encoding.
package shift_pkg;

    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    localparam int MAX_STEP = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_SRA);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between execute-stage control and the shift sequencer.
// master drives the request side, slave is the sequencer.
interface shift_sequencer_if;

    logic        start;
    logic [3:0]  op;
    logic [4:0]  amount;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        s;
    logic        z;
    logic        c;
    logic        v;
    logic        err;

    modport master (
        output start, op, amount, data,
        input  busy, done, result, s, z, c, v, err
    );

    modport slave (
        input  start, op, amount, data,
        output busy, done, result, s, z, c, v, err
    );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-pass 16-bit shifter: sll, rotate-left, srl, sra by 0..15 with carry-out.
// Carry is the last bit shifted out; rotates and unknown opcodes give carry 0.
module shift_sequencer_shifter
    import shift_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [3:0]  d,
    output logic [15:0] y,
    output logic        c
);

    logic [16:0] ext;

    always_comb begin
        ext = '0;
        y   = '0;
        c   = 1'b0;
        case (op)
            OP_SLL: begin
                ext = {1'b0, a} << d;
                y   = ext[15:0];
                c   = ext[16];
            end
            OP_SLR: begin
                y = (a << d) | (a >> (5'd16 - {1'b0, d}));
            end
            OP_SRL: begin
                // a guard bit below the LSB catches the last bit shifted out
                ext = {a, 1'b0} >> d;
                y   = ext[16:1];
                c   = ext[0];
            end
            OP_SRA: begin
                ext = 17'($signed({a, 1'b0}) >>> d);
                y   = ext[16:1];
                c   = ext[0];
            end
            default: begin
                y = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: splits a 0..31 shift into shifter passes of at most MAX_STEP.
// state   | meaning
// ST_IDLE | waiting for start
// ST_RUN  | one shifter pass per cycle until rem reaches 0 (single pass for rotate/invalid op)
// ST_DONE | done pulse; result/flags valid; a new start is accepted here
module shift_sequencer
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus
);

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [15:0] work_q;
    logic [4:0]  rem_q;
    logic        c_reg_q;
    logic [15:0] result_q;
    logic        s_q, z_q, c_q, err_q;

    logic        load, step, last_pass;
    logic [3:0]  step_d;
    logic [4:0]  rem_next;
    logic [15:0] sh_y;
    logic        sh_c;

    shift_sequencer_shifter u_shifter (
        .op (op_q),
        .a  (work_q),
        .d  (step_d),
        .y  (sh_y),
        .c  (sh_c)
    );

    // rotate takes the low four bits of the amount in one pass
    always_comb begin
        step_d = rem_q[3:0];
        if (op_q != OP_SLR && rem_q >= 5'(MAX_STEP)) begin
            step_d = 4'(MAX_STEP);
        end
    end

    assign rem_next  = rem_q - {1'b0, step_d};
    assign last_pass = (op_q == OP_SLR) || !op_is_valid(op_q) || (rem_next == 5'd0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last_pass) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            c_reg_q  <= 1'b0;
            result_q <= '0;
            s_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            err_q    <= 1'b0;
        end else if (load) begin
            op_q    <= bus.op;
            work_q  <= bus.data;
            rem_q   <= bus.amount;
            c_reg_q <= 1'b0;
        end else if (step) begin
            work_q  <= sh_y;
            rem_q   <= rem_next;
            c_reg_q <= sh_c;
            if (last_pass) begin
                result_q <= sh_y;
                s_q      <= sh_y[15];
                z_q      <= (sh_y == 16'd0);
                c_q      <= sh_c;
                err_q    <= !op_is_valid(op_q);
            end
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.s      = s_q;
    assign bus.z      = z_q;
    assign bus.c      = c_q;
    assign bus.v      = 1'b0;
    assign bus.err    = bus.done & err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed shifts, latency, ignored start and mid-run reset.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sequencer_if bus();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] result;
        logic        s;
        logic        z;
        logic        c;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got result=%h", bus.result);
            end else begin
                mon_e = sb.pop_front();
                if (bus.result !== mon_e.result || bus.s !== mon_e.s || bus.z !== mon_e.z ||
                    bus.c !== mon_e.c || bus.err !== mon_e.err || bus.v !== 1'b0) begin
                    failures++;
                    $display("FAIL %s got result=%h s=%b z=%b c=%b v=%b err=%b exp result=%h s=%b z=%b c=%b v=0 err=%b",
                             mon_e.name, bus.result, bus.s, bus.z, bus.c, bus.v, bus.err,
                             mon_e.result, mon_e.s, mon_e.z, mon_e.c, mon_e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // call at a negedge; returns at the negedge of the done cycle
    task automatic run_op(input string name, input logic [3:0] op, input logic [4:0] amt,
                          input logic [15:0] data, input logic [15:0] er, input logic es,
                          input logic ez, input logic ec, input logic eerr,
                          input int exp_lat, input bit poke);
        exp_t e;
        int   lat;
        e.name = name; e.result = er; e.s = es; e.z = ez; e.c = ec; e.err = eerr;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.amount = amt;
        bus.data   = data;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        lat = 1;
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        if (poke) begin
            bus.start  = 1'b1;
            bus.op     = OP_SLL;
            bus.amount = 5'd1;
            bus.data   = 16'hFFFF;
            @(negedge clk);
            bus.start = 1'b0;
            lat = 2;
        end
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.amount = '0;
        bus.data   = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.s, bus.z, bus.c, bus.v, bus.err, bus.result},
            32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sll3",   OP_SLL, 5'd3,  16'h8001, 16'h0008, 0, 0, 0, 0, 2, 0);
        run_op("sra12",  OP_SRA, 5'd12, 16'h8000, 16'hFFF8, 1, 0, 0, 0, 3, 0);
        run_op("srl8",   OP_SRL, 5'd8,  16'h0180, 16'h0001, 0, 0, 1, 0, 3, 0);
        run_op("srl20",  OP_SRL, 5'd20, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 4, 0);
        run_op("slr20",  OP_SLR, 5'd20, 16'h1234, 16'h2341, 0, 0, 0, 0, 2, 0);
        run_op("amt0",   OP_SLL, 5'd0,  16'h0000, 16'h0000, 0, 1, 0, 0, 2, 0);
        run_op("bad_op", 4'd5,   5'd3,  16'h1234, 16'h0000, 0, 1, 0, 1, 2, 0);
        run_op("sll1c",  OP_SLL, 5'd1,  16'h8000, 16'h0000, 0, 1, 1, 0, 2, 0);
        run_op("srl0",   OP_SRL, 5'd0,  16'hA5A5, 16'hA5A5, 1, 0, 0, 0, 2, 0);
        @(negedge clk);
        chk("idle_after_done", {bus.busy, bus.done}, 32'd0);

        run_op("sra14_poke", OP_SRA, 5'd14, 16'h8100, 16'hFFFE, 1, 0, 0, 0, 3, 1);
        repeat (3) @(negedge clk);
        chk("poke_ignored", {bus.busy, bus.done}, 32'd0);

        bus.start  = 1'b1;
        bus.op     = OP_SRA;
        bus.amount = 5'd14;
        bus.data   = 16'h8100;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_run", {bus.busy, bus.done, bus.s, bus.z, bus.c, bus.err, bus.result}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sra14_after_reset", OP_SRA, 5'd14, 16'h8100, 16'hFFFE, 1, 0, 0, 0, 3, 0);
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
